// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode digit scanner with per-digit blanking, PWM brightness,
// frame-synchronous pattern capture and a frame-start strobe. Optional macro: DEADTIME_EN.
module seg_scan_mux #(
    parameter int               DIGITS          = 4,
    parameter int               SEG_W           = 7,
    parameter int               TICKS_PER_DIGIT = 833_334,
    parameter int               BRIGHT_W        = 4,
    parameter logic [SEG_W-1:0] SEG_OFF         = '1,
    parameter int               DEAD_TICKS      = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DIGITS*SEG_W-1:0]   din,
    input  logic [DIGITS-1:0]         blank,
    input  logic [BRIGHT_W-1:0]       bright,
    output logic [DIGITS-1:0]         pos,
    output logic [SEG_W-1:0]          dout,
    output logic                      frame_start
);

    localparam int CNT_W = $clog2(TICKS_PER_DIGIT);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Reject configurations the counters cannot represent.
    if (DIGITS < 1 || TICKS_PER_DIGIT < 2 || DEAD_TICKS >= TICKS_PER_DIGIT) begin : g_bad_cfg
        $error("seg_scan_mux: invalid parameter combination");
    end

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BRIGHT_W-1:0]     pcnt_q, pcnt_d;
    logic [DIGITS*SEG_W-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]       pos_q, pos_d;
    logic [SEG_W-1:0]        dout_q, dout_d;
    logic                    frame_start_q, frame_start_d;

    logic                    capture;
    logic                    lit;
    logic [SEG_W-1:0]        sel_seg;

    assign capture = en && (idx_q == '0) && (cnt_q == '0);
    // The capture cycle must already display the freshly sampled din, not the stale shadow.
    assign sel_seg = capture ? din[int'(idx_q)*SEG_W +: SEG_W]
                             : shadow_q[int'(idx_q)*SEG_W +: SEG_W];

`ifdef DEADTIME_EN
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_TICKS);
    assign lit = en && !blank[idx_q] && (pcnt_q <= bright) && (cnt_q >= DEAD_LIM);
`else
    assign lit = en && !blank[idx_q] && (pcnt_q <= bright);
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        pcnt_d        = pcnt_q;
        shadow_d      = shadow_q;
        pos_d         = '1;
        dout_d        = SEG_OFF;
        frame_start_d = 1'b0;

        if (en) begin
            frame_start_d = capture;
            if (capture) begin
                shadow_d = din;
            end
            if (lit) begin
                pos_d  = ~(DIGITS'(1) << idx_q);
                dout_d = sel_seg;
            end

            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                pcnt_d = '0;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                pcnt_d = pcnt_q + BRIGHT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pcnt_q        <= '0;
            // NOTE: the shadow store is reset because dark-at-reset must not depend on power-up contents.
            shadow_q      <= {DIGITS{SEG_OFF}};
            pos_q         <= '1;
            dout_q        <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pcnt_q        <= pcnt_d;
            shadow_q      <= shadow_d;
            pos_q         <= pos_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pos         = pos_q;
    assign dout        = dout_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a slot/phase reference model queues expected outputs,
// a monitor compares each registered output cycle.
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 7;
    localparam int TICKS  = 8;
    localparam int BW     = 2;
    localparam int DEAD   = 2;

    typedef struct {
        logic [DIGITS-1:0] pos;
        logic [SEG_W-1:0]  dout;
        logic              fs;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en  = 1'b0;
    logic [DIGITS*SEG_W-1:0] din = '0;
    logic [DIGITS-1:0]       blank = '0;
    logic [BW-1:0]           bright = '1;
    logic [DIGITS-1:0]       pos;
    logic [SEG_W-1:0]        dout;
    logic                    frame_start;

    seg_scan_mux #(
        .DIGITS(DIGITS), .SEG_W(SEG_W), .TICKS_PER_DIGIT(TICKS),
        .BRIGHT_W(BW), .SEG_OFF(7'h7F), .DEAD_TICKS(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .blank(blank),
        .bright(bright), .pos(pos), .dout(dout), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: position within the slot, digit shown, and the frame's captured patterns.
    int   m_tick  = 0;
    int   m_digit = 0;
    int   m_frame[DIGITS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Compute what the display should show for the inputs now applied, push it, advance a cycle.
    task automatic step();
        exp_t e;
        bit   is_frame;
        bit   on;
        e.pos = '1;
        e.dout = 7'h7F;
        e.fs = 1'b0;
        if (rst) begin
            m_tick = 0;
            m_digit = 0;
            foreach (m_frame[i]) m_frame[i] = 'h7F;
        end else if (en) begin
            is_frame = (m_digit == 0) && (m_tick == 0);
            if (is_frame)
                foreach (m_frame[i]) m_frame[i] = int'(din[i*SEG_W +: SEG_W]);
            // PWM phase restarts each slot, so it is the slot position modulo the PWM period.
            on = !blank[m_digit] && ((m_tick % (1 << BW)) <= int'(bright));
`ifdef DEADTIME_EN
            if (m_tick < DEAD) on = 1'b0;
`endif
            if (on) begin
                e.pos = '1;
                e.pos[m_digit] = 1'b0;
                e.dout = SEG_W'(m_frame[m_digit]);
            end
            e.fs = is_frame;
            m_tick++;
            if (m_tick == TICKS) begin
                m_tick = 0;
                m_digit = (m_digit + 1) % DIGITS;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pos", 32'(pos), 32'(e.pos));
                check("dout", 32'(dout), 32'(e.dout));
                check("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin : stimulus
        int guard;
        foreach (m_frame[i]) m_frame[i] = 'h7F;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; din = {7'h08, 7'h04, 7'h02, 7'h01};
        run(2);

        // Plain scan at full brightness.
        rst = 1'b0; bright = 2'd3; blank = '0;
        run(40);

        // Half duty with digit 2 blanked; align first to a frame start.
        guard = 0;
        while (!(m_digit == 0 && m_tick == 0) && guard < 64) begin step(); guard++; end
        bright = 2'd1; blank = 4'b0100;
        run(32);

        // Mid-frame din change while digit 1 is shown must wait for the next frame.
        bright = 2'd3; blank = '0;
        guard = 0;
        while (m_digit != 1 && guard < 64) begin step(); guard++; end
        din[0 +: SEG_W] = 7'h40;
        run(40);

        // Enable gap starting at tick 3 of slot 2.
        guard = 0;
        while (!(m_digit == 2 && m_tick == 3) && guard < 64) begin step(); guard++; end
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(20);

        // One-cycle reset in the middle of slot 2.
        guard = 0;
        while (!(m_digit == 2 && m_tick == 4) && guard < 64) begin step(); guard++; end
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        din = {7'h11, 7'h22, 7'h33, 7'h44};
        run(20);

        // Randomised traffic: en gaps, blanking, brightness, din updates and rare resets.
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) blank = DIGITS'($urandom);
            if ($urandom_range(0, 20) == 0) bright = BW'($urandom);
            if ($urandom_range(0, 5) == 0) din = (DIGITS*SEG_W)'({$urandom, $urandom});
            step();
        end
        rst = 1'b0; en = 1'b1;
        run(4);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
